// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: constants shared by the sparse MAC unit and its drain stage.
package psum_drain_pkg;

    localparam int NUM_CH         = 4;
    localparam int CH_IDX_WIDTH   = 2;
    localparam int NUM_BANKS      = 2;
    localparam int CNT_WIDTH      = 2;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PSUM_WIDTH = 4 * DEF_DATA_WIDTH;
    localparam int DEF_OUT_WIDTH  = 16;

endpackage

// File: rtl/psum_narrow.sv
// psum_narrow: combinational PSUM -> OUT width reduction.
// Build option: PSUM_DRAIN_SAT_EN selects unsigned saturation; otherwise
// the low OUT_W bits are passed through and no saturation logic exists.
module psum_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

`ifdef PSUM_DRAIN_SAT_EN
    generate
        if (OUT_W < IN_W) begin : g_sat
            // Clamp to all-ones whenever any bit above the output range is set.
            always_comb begin
                dout = OUT_W'(din);
                if (|din[IN_W-1:OUT_W]) begin
                    dout = '1;
                end
            end
        end else begin : g_pass
            assign dout = OUT_W'(din);
        end
    endgenerate
`else
    // Plain truncation to the low OUT_W bits.
    assign dout = OUT_W'(din);
`endif

endmodule

// File: rtl/psum_drain.sv
// psum_drain: captures the four MAC partial sums on the falling edge of
// Block_control, double-buffers up to two blocks and streams them one
// channel per beat (0,1,2,3) in capture order.
// Build option: PSUM_DRAIN_SAT_EN (see psum_narrow) makes narrowing saturate.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PSUM_WIDTH = DEF_PSUM_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
    input  logic                    Clk,
    input  logic                    rst,
    input  logic                    Block_control,
    input  logic [PSUM_WIDTH-1:0]   Psum_0,
    input  logic [PSUM_WIDTH-1:0]   Psum_1,
    input  logic [PSUM_WIDTH-1:0]   Psum_2,
    input  logic [PSUM_WIDTH-1:0]   Psum_3,
    output logic [OUT_WIDTH-1:0]    Out_data,
    output logic [CH_IDX_WIDTH-1:0] Out_chan,
    output logic                    Out_last,
    output logic                    Out_valid,
    input  logic                    Out_ready,
    output logic                    Busy,
    output logic                    Overflow
);

    // Elaboration-time guard against impossible width combinations.
    generate
        if (OUT_WIDTH > PSUM_WIDTH || PSUM_WIDTH < DATA_WIDTH) begin : g_bad_cfg
            $error("psum_drain: OUT_WIDTH must be <= PSUM_WIDTH and PSUM_WIDTH >= DATA_WIDTH");
        end
    endgenerate

    logic                    block_d;
    logic [CNT_WIDTH-1:0]    count;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [CH_IDX_WIDTH-1:0] chan_idx;
    logic [PSUM_WIDTH-1:0]   bank [NUM_BANKS][NUM_CH];

    logic                    capture;
    logic                    has_data;
    logic                    beat;
    logic                    pop;
    logic                    accept;
    logic [OUT_WIDTH-1:0]    rd_narrow;

    // Stream handshake: Out_valid depends on registered state only and never
    // on Out_ready; a beat moves on a rising edge with Out_valid & Out_ready,
    // and while Out_ready is low the presented beat holds steady.
    // Edge detect, pop and accept decisions for the current cycle.
    always_comb begin
        capture  = block_d & ~Block_control;
        has_data = (count != '0);
        beat     = has_data & Out_ready;
        pop      = beat & (chan_idx == CH_IDX_WIDTH'(NUM_CH - 1));
        // A full buffer still accepts when the oldest block leaves this cycle.
        accept   = capture & ((count != CNT_WIDTH'(NUM_BANKS)) | pop);
    end

    // Bank storage, pointers, occupancy counter and sticky overflow.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            block_d  <= 1'b0;
            count    <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            chan_idx <= '0;
            Overflow <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    bank[b][c] <= '0;
                end
            end
        end else begin
            block_d <= Block_control;
            if (accept) begin
                bank[wr_ptr][0] <= Psum_0;
                bank[wr_ptr][1] <= Psum_1;
                bank[wr_ptr][2] <= Psum_2;
                bank[wr_ptr][3] <= Psum_3;
                wr_ptr          <= ~wr_ptr;
            end
            if (capture && !accept) begin
                Overflow <= 1'b1;
            end
            if (beat) begin
                // Channel 3 wraps naturally to 0 at the end of a block.
                chan_idx <= chan_idx + 1'b1;
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    psum_narrow #(
        .IN_W  (PSUM_WIDTH),
        .OUT_W (OUT_WIDTH)
    ) u_narrow (
        .din  (bank[rd_ptr][chan_idx]),
        .dout (rd_narrow)
    );

    // Stream outputs are forced quiet while reset is asserted.
    assign Out_valid = rst & has_data;
    assign Busy      = rst & has_data;
    assign Out_chan  = rst ? chan_idx : '0;
    assign Out_data  = rst ? rd_narrow : '0;
    assign Out_last  = Out_valid & (chan_idx == CH_IDX_WIDTH'(NUM_CH - 1));

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed bench for psum_drain; expected values are written
// out by hand per step. Honours PSUM_DRAIN_SAT_EN for the narrowing step.
module tb_psum_drain;

    localparam int PW = 32;
    localparam int OW = 16;

    logic          Clk = 1'b0;
    logic          rst = 1'b0;
    logic          Block_control = 1'b0;
    logic [PW-1:0] Psum_0 = '0;
    logic [PW-1:0] Psum_1 = '0;
    logic [PW-1:0] Psum_2 = '0;
    logic [PW-1:0] Psum_3 = '0;
    logic [OW-1:0] Out_data;
    logic [1:0]    Out_chan;
    logic          Out_last;
    logic          Out_valid;
    logic          Out_ready = 1'b0;
    logic          Busy;
    logic          Overflow;

    int tests = 0;
    int fails = 0;

    psum_drain #(
        .DATA_WIDTH (8),
        .PSUM_WIDTH (PW),
        .OUT_WIDTH  (OW)
    ) dut (
        .Clk           (Clk),
        .rst           (rst),
        .Block_control (Block_control),
        .Psum_0        (Psum_0),
        .Psum_1        (Psum_1),
        .Psum_2        (Psum_2),
        .Psum_3        (Psum_3),
        .Out_data      (Out_data),
        .Out_chan      (Out_chan),
        .Out_last      (Out_last),
        .Out_valid     (Out_valid),
        .Out_ready     (Out_ready),
        .Busy          (Busy),
        .Overflow      (Overflow)
    );

    // Clock generation.
    always #5 Clk = ~Clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present four partial sums, raise then drop Block_control; returns just
    // after the capture edge with the MAC inputs overwritten by junk.
    task automatic capture(input logic [PW-1:0] a, input logic [PW-1:0] b,
                           input logic [PW-1:0] c, input logic [PW-1:0] d);
        Psum_0 = a; Psum_1 = b; Psum_2 = c; Psum_3 = d;
        Block_control = 1'b1;
        tick();
        Block_control = 1'b0;
        tick();
        Psum_0 = 32'hDEAD_0000; Psum_1 = 32'hDEAD_0001;
        Psum_2 = 32'hDEAD_0002; Psum_3 = 32'hDEAD_0003;
    endtask

    // Check the presented beat, then drive ready for the next edge.
    task automatic beat(input string tag, input logic rdy, input logic [OW-1:0] d, input logic [1:0] ch);
        Out_ready = rdy;
        check({tag, "_valid"}, 32'(Out_valid), 32'd1);
        check({tag, "_data"},  32'(Out_data),  32'(d));
        check({tag, "_chan"},  32'(Out_chan),  32'(ch));
        check({tag, "_last"},  32'(Out_last),  32'(ch == 2'd3));
        tick();
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(Out_valid), 32'd0);
        check({tag, "_busy"},  32'(Busy),      32'd0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        expect_idle("rst");
        check("rst_ovf",  32'(Overflow), 32'd0);
        check("rst_data", 32'(Out_data), 32'd0);
        check("rst_chan", 32'(Out_chan), 32'd0);
        check("rst_last", 32'(Out_last), 32'd0);
        rst = 1'b1;
        tick();
        expect_idle("post_rst");

        // 1: single capture, ready held high
        Psum_0 = 10; Psum_1 = 20; Psum_2 = 30; Psum_3 = 40;
        Block_control = 1'b1;
        tick();
        expect_idle("t1_pre");
        Block_control = 1'b0;
        Out_ready = 1'b1;
        tick();
        Psum_0 = 32'h999; Psum_1 = 32'h999; Psum_2 = 32'h999; Psum_3 = 32'h999;
        check("t1_busy", 32'(Busy), 32'd1);
        beat("t1_b0", 1'b1, 16'd10, 2'd0);
        beat("t1_b1", 1'b1, 16'd20, 2'd1);
        beat("t1_b2", 1'b1, 16'd30, 2'd2);
        beat("t1_b3", 1'b1, 16'd40, 2'd3);
        expect_idle("t1_end");
        Out_ready = 1'b0;
        tick(); tick();
        expect_idle("t1_hold_low");

        // 2: backpressure
        capture(10, 20, 30, 40);
        beat("t2_s0", 1'b1, 16'd10, 2'd0);
        beat("t2_s1", 1'b0, 16'd20, 2'd1);
        beat("t2_s2", 1'b0, 16'd20, 2'd1);
        beat("t2_s3", 1'b1, 16'd20, 2'd1);
        beat("t2_s4", 1'b0, 16'd30, 2'd2);
        beat("t2_s5", 1'b1, 16'd30, 2'd2);
        beat("t2_s6", 1'b1, 16'd40, 2'd3);
        expect_idle("t2_end");
        Out_ready = 1'b0;

        // 5: narrowing
        capture(32'h0001_2345, 32'h0000_FFFF, 32'h1234_0000, 32'h0000_0042);
`ifdef PSUM_DRAIN_SAT_EN
        beat("t5_b0", 1'b1, 16'hFFFF, 2'd0);
        beat("t5_b1", 1'b1, 16'hFFFF, 2'd1);
        beat("t5_b2", 1'b1, 16'hFFFF, 2'd2);
`else
        beat("t5_b0", 1'b1, 16'h2345, 2'd0);
        beat("t5_b1", 1'b1, 16'hFFFF, 2'd1);
        beat("t5_b2", 1'b1, 16'h0000, 2'd2);
`endif
        beat("t5_b3", 1'b1, 16'h0042, 2'd3);
        expect_idle("t5_end");
        Out_ready = 1'b0;

        // 3: double buffer then overflow
        capture(1, 2, 3, 4);
        capture(5, 6, 7, 8);
        check("t3_busy", 32'(Busy), 32'd1);
        check("t3_ovf0", 32'(Overflow), 32'd0);
        capture(9, 10, 11, 12);
        check("t3_ovf1", 32'(Overflow), 32'd1);
        for (int i = 0; i < 8; i++) begin
            beat("t3_drain", 1'b1, OW'(i + 1), 2'(i % 4));
        end
        expect_idle("t3_end");
        check("t3_ovf_sticky", 32'(Overflow), 32'd1);
        Out_ready = 1'b0;

        // 6: reset mid-drain
        capture(11, 22, 33, 44);
        beat("t6_b0", 1'b1, 16'd11, 2'd0);
        beat("t6_b1", 1'b1, 16'd22, 2'd1);
        rst = 1'b0;
        tick();
        expect_idle("t6_rst");
        check("t6_ovf",  32'(Overflow), 32'd0);
        check("t6_data", 32'(Out_data), 32'd0);
        check("t6_chan", 32'(Out_chan), 32'd0);
        check("t6_last", 32'(Out_last), 32'd0);
        tick();
        rst = 1'b1;
        Out_ready = 1'b0;
        tick();
        expect_idle("t6_after");
        capture(7, 8, 9, 10);
        beat("t6_n0", 1'b1, 16'd7,  2'd0);
        beat("t6_n1", 1'b1, 16'd8,  2'd1);
        beat("t6_n2", 1'b1, 16'd9,  2'd2);
        beat("t6_n3", 1'b1, 16'd10, 2'd3);
        expect_idle("t6_end");
        Out_ready = 1'b0;

        // 4: capture coinciding with the pop of the oldest block
        capture(100, 101, 102, 103);
        capture(200, 201, 202, 203);
        Psum_0 = 300; Psum_1 = 301; Psum_2 = 302; Psum_3 = 303;
        Block_control = 1'b1;
        beat("t4_a0", 1'b1, 16'd100, 2'd0);
        beat("t4_a1", 1'b1, 16'd101, 2'd1);
        beat("t4_a2", 1'b1, 16'd102, 2'd2);
        Block_control = 1'b0;
        beat("t4_a3", 1'b1, 16'd103, 2'd3);
        Psum_0 = '0; Psum_1 = '0; Psum_2 = '0; Psum_3 = '0;
        check("t4_ovf", 32'(Overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat("t4_b", 1'b1, OW'(200 + i), 2'(i));
        end
        for (int i = 0; i < 4; i++) begin
            beat("t4_c", 1'b1, OW'(300 + i), 2'(i));
        end
        expect_idle("t4_end");
        check("t4_ovf_end", 32'(Overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
Name: psum_drain

Overview:
Downstream drain stage for the four-channel sparse MAC unit. Detects the end of an accumulation block, when Block_control falls 1->0, and captures the four partial sums in that same cycle. The MAC's outputs are valid only during that first low cycle. Buffers up to two captured blocks and serialises them one channel per beat over a valid/ready stream toward the output SRAM writer.

Parameters:
DATA_WIDTH, 8, MAC operand width.
PSUM_WIDTH, 32, partial-sum width (4*DATA_WIDTH).
OUT_WIDTH, 16, streamed output word width (<= PSUM_WIDTH).

Ports:
Clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-low reset
Block_control  input  1  same accumulate-enable signal that drives the MAC unit
Psum_0  input  PSUM_WIDTH  MAC channel-0 result, valid only in the first Block_control-low cycle
Psum_1  input  PSUM_WIDTH  channel 1
Psum_2  input  PSUM_WIDTH  channel 2
Psum_3  input  PSUM_WIDTH  channel 3
Out_data  output  OUT_WIDTH  streamed partial sum
Out_chan  output  2  channel index of Out_data
Out_last  output  1  high on the channel-3 beat of a block
Out_valid  output  1  stream valid
Out_ready  input  1  stream ready from consumer
Busy  output  1  at least one bank holds undrained data
Overflow  output  1  sticky; a capture was dropped

Behaviour:
- Reset: when rst==0 at a clock edge, all of the following clear to 0: block_d, count, wr_ptr, rd_ptr, chan_idx, Overflow, and the bank contents. While in reset: Out_valid=0, Busy=0, Out_last=0, Out_data=0, Out_chan=0.
- Reset mid-drain discards both banks. No beat is emitted after the reset edge.
- Edge detect: block_d is a register of Block_control. capture = block_d & ~Block_control. No spurious capture after reset, because block_d resets to 0.
- Storage: two banks, each holding 4 x PSUM_WIDTH. wr_ptr and rd_ptr are 1-bit. count ranges 0..2.
- Capture handling at the edge where capture==1:
  - If count<2, or (count==2 and a pop completes in the same cycle): Psum_0..3 are written to bank[wr_ptr], wr_ptr toggles, and count increments (net change 0 if a pop also completes).
  - Otherwise the data is dropped and Overflow is set to 1. Overflow clears only on reset.
- Read path:
  - Out_valid = (count!=0). All stream outputs are derived from registers only; there is no combinational path from Out_ready to Out_valid.
  - Out_data = narrow(bank[rd_ptr][chan_idx]).
  - Out_chan = chan_idx.
  - Out_last = Out_valid & (chan_idx==3).
- Handshake:
  - A beat transfers when Out_valid & Out_ready at a clock edge, and chan_idx then increments.
  - On the chan_idx==3 beat, chan_idx wraps to 0, rd_ptr toggles and count decrements ("pop complete").
  - While Out_ready=0, Out_data, Out_chan and Out_last stay stable.
- Latency: capture at edge k gives Out_valid=1 in the cycle after edge k (count 0->1). With Out_ready held 1, the 4 beats are emitted on consecutive cycles, and throughput is 1 word per cycle.
- Channel order is always 0,1,2,3. Blocks are drained in capture order.
- Busy = (count!=0).
- narrow(): default is truncation to the low OUT_WIDTH bits (unsigned).
- Block_control held at 0 for many cycles produces only one capture.
- Block_control toggling 1,0,1,0 produces one capture per falling edge.

Optional Feature:
PSUM_DRAIN_SAT_EN:
- Defined: narrow() saturates unsigned. Any value > 2^OUT_WIDTH-1 is emitted as all-ones.
- Undefined: narrow() truncates to the low OUT_WIDTH bits. No saturation logic is built.
- Either way, the bank storage keeps the full PSUM_WIDTH.

Decomposition:
- Shared package holds: NUM_CH=4, CH_IDX_WIDTH=2, NUM_BANKS=2, PSUM_WIDTH and OUT_WIDTH defaults. The MAC unit uses the same constants.
- One sub-module, psum_narrow: combinational PSUM_WIDTH->OUT_WIDTH truncate/saturate, containing the PSUM_DRAIN_SAT_EN ifdef.
- Banks, pointers, counter and edge detect live in psum_drain.

Test Plan:
1. Single capture: Psum=10,20,30,40, Block_control 1->0, Out_ready=1 -> Out_valid high 1 cycle after capture. Beats 10,20,30,40 with Out_chan 0..3 on consecutive cycles. Out_last only on 40. Busy falls after the last beat.
2. Backpressure: same as test 1, Out_ready toggled 1,0,0,1,... -> Out_data/Out_chan held stable during ready=0. Exactly 4 beats total, in order.
3. Double buffer: Out_ready=0. Capture A=1,2,3,4, then B=5,6,7,8 -> count=2, Overflow=0. A third capture C -> Overflow=1. Release ready -> stream is 1..8, C absent.
4. Simultaneous pop/capture: count=2, with the capture edge coinciding with A's chan-3 handshake -> C accepted, Overflow=0. Stream is A, B, C.
5. Narrowing: Psum_0=0x0001_2345 -> Out_data=0xFFFF with PSUM_DRAIN_SAT_EN defined, 0x2345 without.
6. Reset mid-drain: rst=0 after 2 beats of a block -> Out_valid=0 and Busy=0 from the reset edge, Overflow=0. A capture after reset streams normally.
